// File: rtl/trans_scheduler.sv
// trans_scheduler
// Sequences the transactions of a memory-checker test. After a start pulse it
// issues one write and/or read command at a time to the Avalon-MM engines over
// a valid/ready handshake. It waits for each engine completion, then generates
// the next address from the selected address mode. It reports busy, a one-cycle
// finish pulse, a sticky compare-error flag and the completed-transaction count.
//
// Ports
//   clk_i, rst_i          clock, asynchronous active-high reset
//   test_start_i          start pulse (ignored while a test runs)
//   test_mode_i           01 read-only, 10 write-only, 11 write-and-check
//   addr_mode_i           000 FIX, 001 RND, 010 RUN_0, 011 RUN_1, 100 INC
//   base_addr_i           fixed address / LFSR seed / INC start
//   words_i, trans_cnt_i  words per command, number of transactions
//   cmd_valid_o/ready_i   command handshake; type (0 wr, 1 rd), addr, words
//   cmd_done_i, err_i     engine completion pulse, compare error pulse
//   busy_o, finish_o, err_o, trans_done_o   status back to the CSR block
module trans_scheduler #(
  parameter int ADDR_W  = 32,
  parameter int WORDS_W = 10,
  parameter int CNT_W   = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               test_start_i,
  input  logic [1:0]         test_mode_i,
  input  logic [2:0]         addr_mode_i,
  input  logic [ADDR_W-1:0]  base_addr_i,
  input  logic [WORDS_W-1:0] words_i,
  input  logic [CNT_W-1:0]   trans_cnt_i,
  output logic               cmd_valid_o,
  input  logic               cmd_ready_i,
  output logic               cmd_type_o,
  output logic [ADDR_W-1:0]  cmd_addr_o,
  output logic [WORDS_W-1:0] cmd_words_o,
  input  logic               cmd_done_i,
  input  logic               err_i,
  output logic               busy_o,
  output logic               finish_o,
  output logic               err_o,
  output logic [CNT_W-1:0]   trans_done_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE_WR, S_WAIT_WR, S_ISSUE_RD, S_WAIT_RD, S_FINISH
  } state_e;

  localparam logic [1:0] MODE_NONE = 2'b00;
  localparam logic [1:0] MODE_RD   = 2'b01;
  localparam logic [1:0] MODE_WC   = 2'b11;

  localparam logic [2:0] AM_FIX  = 3'd0;
  localparam logic [2:0] AM_RND  = 3'd1;
  localparam logic [2:0] AM_RUN0 = 3'd2;
  localparam logic [2:0] AM_RUN1 = 3'd3;
  localparam logic [2:0] AM_INC  = 3'd4;

  // Tap mask of x^32+x^22+x^2+x+1, keeping only the taps that fit in ADDR_W.
  function automatic logic [ADDR_W-1:0] lfsr_taps();
    logic [ADDR_W-1:0] m;
    m = '0;
    for (int i = 0; i < ADDR_W; i++)
      if (i == 0 || i == 1 || i == 2 || i == 22) m[i] = 1'b1;
    return m;
  endfunction

  localparam logic [ADDR_W-1:0] TAPS = lfsr_taps();

  function automatic logic [ADDR_W-1:0] lfsr_step(input logic [ADDR_W-1:0] a);
    return a[ADDR_W-1] ? ((a << 1) ^ TAPS) : (a << 1);
  endfunction

  function automatic logic [ADDR_W-1:0] rotl(input logic [ADDR_W-1:0] a);
    return {a[ADDR_W-2:0], a[ADDR_W-1]};
  endfunction

  function automatic logic [ADDR_W-1:0] first_addr(input logic [2:0]        am,
                                                   input logic [ADDR_W-1:0] base);
    case (am)
      AM_RND:  return (base == '0) ? ADDR_W'(1) : base;
      AM_RUN0: return ~ADDR_W'(1);
      AM_RUN1: return ADDR_W'(1);
      default: return base;
    endcase
  endfunction

  state_e               state_q, state_d;
  logic [1:0]           mode_q, mode_d;
  logic [2:0]           amode_q, amode_d;
  logic [WORDS_W-1:0]   words_q, words_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [CNT_W-1:0]     done_cnt_q, done_cnt_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [ADDR_W-1:0]    lfsr_q, lfsr_d;
  logic                 type_q, type_d;
  logic                 err_q, err_d;
  logic                 busy;
  logic                 err_now;
  logic                 trans_end;

  assign cmd_valid_o  = (state_q == S_ISSUE_WR) || (state_q == S_ISSUE_RD);
  assign busy         = cmd_valid_o || (state_q == S_WAIT_WR) || (state_q == S_WAIT_RD);
  assign busy_o       = busy;
  assign finish_o     = (state_q == S_FINISH);
  assign err_o        = err_q;
  assign cmd_type_o   = type_q;
  assign cmd_addr_o   = addr_q;
  assign cmd_words_o  = words_q;
  assign trans_done_o = done_cnt_q;

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    amode_d    = amode_q;
    words_d    = words_q;
    cnt_d      = cnt_q;
    done_cnt_d = done_cnt_q;
    addr_d     = addr_q;
    lfsr_d     = lfsr_q;
    type_d     = type_q;
    err_d      = err_q;
    trans_end  = 1'b0;

    // An error in the same cycle as a completion must already stop the test.
    err_now = err_q || (busy && err_i);
    if (busy && err_i) err_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (test_start_i) begin
          mode_d     = test_mode_i;
          amode_d    = addr_mode_i;
          words_d    = words_i;
          cnt_d      = trans_cnt_i;
          done_cnt_d = '0;
          err_d      = 1'b0;
          addr_d     = first_addr(addr_mode_i, base_addr_i);
          if (addr_mode_i == AM_RND) lfsr_d = addr_d;
          if (trans_cnt_i == '0 || test_mode_i == MODE_NONE || addr_mode_i > AM_INC) begin
            state_d = S_FINISH;
          end else if (test_mode_i == MODE_RD) begin
            state_d = S_ISSUE_RD;
            type_d  = 1'b1;
          end else begin
            state_d = S_ISSUE_WR;
            type_d  = 1'b0;
          end
        end
      end
      S_ISSUE_WR: if (cmd_ready_i) state_d = S_WAIT_WR;
      S_ISSUE_RD: if (cmd_ready_i) state_d = S_WAIT_RD;
      S_WAIT_WR: begin
        if (cmd_done_i) begin
          if (mode_q == MODE_WC) begin
            // The read-back of a write reuses the same address.
            if (err_now) begin
              state_d = S_FINISH;
            end else begin
              state_d = S_ISSUE_RD;
              type_d  = 1'b1;
            end
          end else begin
            trans_end = 1'b1;
          end
        end
      end
      S_WAIT_RD: if (cmd_done_i) trans_end = 1'b1;
      S_FINISH:  state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase

    if (trans_end) begin
      done_cnt_d = done_cnt_q + CNT_W'(1);
      if (done_cnt_d == cnt_q || err_now) begin
        state_d = S_FINISH;
      end else begin
        case (amode_q)
          AM_RND: begin
            lfsr_d = lfsr_step(lfsr_q);
            addr_d = lfsr_d;
          end
          AM_RUN0, AM_RUN1: addr_d = rotl(addr_q);
          AM_INC:           addr_d = addr_q + ADDR_W'(words_q);
          default:          addr_d = addr_q;
        endcase
        if (mode_q == MODE_RD) begin
          state_d = S_ISSUE_RD;
          type_d  = 1'b1;
        end else begin
          state_d = S_ISSUE_WR;
          type_d  = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      mode_q     <= '0;
      amode_q    <= '0;
      words_q    <= '0;
      cnt_q      <= '0;
      done_cnt_q <= '0;
      addr_q     <= '0;
      lfsr_q     <= ADDR_W'(1);
      type_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      amode_q    <= amode_d;
      words_q    <= words_d;
      cnt_q      <= cnt_d;
      done_cnt_q <= done_cnt_d;
      addr_q     <= addr_d;
      lfsr_q     <= lfsr_d;
      type_q     <= type_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_trans_scheduler.sv
// Testbench for trans_scheduler: a randomized engine (ready backpressure,
// completion delay, error injection) drives the scheduler, and every accepted
// command and status output is compared with a behavioural model of the test.
module tb_trans_scheduler;
  localparam int ADDR_W  = 32;
  localparam int WORDS_W = 10;
  localparam int CNT_W   = 16;

  logic               clk_i = 1'b0;
  logic               rst_i;
  logic               test_start_i;
  logic [1:0]         test_mode_i;
  logic [2:0]         addr_mode_i;
  logic [ADDR_W-1:0]  base_addr_i;
  logic [WORDS_W-1:0] words_i;
  logic [CNT_W-1:0]   trans_cnt_i;
  logic               cmd_valid_o;
  logic               cmd_ready_i;
  logic               cmd_type_o;
  logic [ADDR_W-1:0]  cmd_addr_o;
  logic [WORDS_W-1:0] cmd_words_o;
  logic               cmd_done_i;
  logic               err_i;
  logic               busy_o;
  logic               finish_o;
  logic               err_o;
  logic [CNT_W-1:0]   trans_done_o;

  int total = 0;
  int bad   = 0;

  trans_scheduler #(.ADDR_W(ADDR_W), .WORDS_W(WORDS_W), .CNT_W(CNT_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .test_start_i(test_start_i),
    .test_mode_i(test_mode_i), .addr_mode_i(addr_mode_i),
    .base_addr_i(base_addr_i), .words_i(words_i), .trans_cnt_i(trans_cnt_i),
    .cmd_valid_o(cmd_valid_o), .cmd_ready_i(cmd_ready_i),
    .cmd_type_o(cmd_type_o), .cmd_addr_o(cmd_addr_o), .cmd_words_o(cmd_words_o),
    .cmd_done_i(cmd_done_i), .err_i(err_i), .busy_o(busy_o),
    .finish_o(finish_o), .err_o(err_o), .trans_done_o(trans_done_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Address of transaction i, derived directly from the address-mode rules.
  function automatic logic [31:0] exp_addr(input logic [2:0] am, input logic [31:0] base,
                                           input logic [9:0] w, input int i);
    logic [31:0] s;
    logic [63:0] sum;
    case (am)
      3'd1: begin
        s = (base == 32'd0) ? 32'd1 : base;
        for (int k = 0; k < i; k++)
          s = s[31] ? ((s << 1) ^ 32'h0040_0007) : (s << 1);
        return s;
      end
      3'd2: return ~(32'd1 << (i % 32));
      3'd3: return 32'd1 << (i % 32);
      3'd4: begin
        sum = 64'(base) + 64'(w) * 64'(i);
        return sum[31:0];
      end
      default: return base;
    endcase
  endfunction

  task automatic run(input string name, input logic [1:0] mode, input logic [2:0] am,
                     input logic [31:0] base, input logic [9:0] w, input logic [15:0] cnt,
                     input int err_k, input int rdy_mode, input int rst_k);
    logic [31:0] ea[$];
    bit          et[$];
    int          cpt, exp_n, exp_td, n_acc, wait_ctr, stall;
    bit          exp_err, degen, start_chk, follow, prev_acc, held_valid;
    bit          waiting, fin_seen, err_sent, err_early;
    logic [42:0] held;

    degen = (cnt == 0) || (mode == 2'b00) || (am > 3'd4);
    cpt   = (mode == 2'b11) ? 2 : 1;
    if (!degen) begin
      for (int i = 0; i < int'(cnt); i++) begin
        if (mode != 2'b01) begin ea.push_back(exp_addr(am, base, w, i)); et.push_back(1'b0); end
        if (mode != 2'b10) begin ea.push_back(exp_addr(am, base, w, i)); et.push_back(1'b1); end
      end
    end
    exp_n   = ea.size();
    exp_td  = degen ? 0 : int'(cnt);
    exp_err = 1'b0;
    if (err_k >= 0 && err_k < exp_n) begin
      exp_n   = err_k + 1;
      exp_td  = (err_k + 1) / cpt;
      exp_err = 1'b1;
    end

    @(negedge clk_i);
    test_mode_i  = mode;
    addr_mode_i  = am;
    base_addr_i  = base;
    words_i      = w;
    trans_cnt_i  = cnt;
    test_start_i = 1'b1;
    cmd_ready_i  = 1'b0;
    cmd_done_i   = 1'b0;
    err_i        = 1'b0;
    n_acc = 0; wait_ctr = 0; held = '0;
    start_chk = 1; follow = 0; prev_acc = 0; held_valid = 0;
    waiting = 0; fin_seen = 0; err_sent = 0; err_early = 0;
    stall = (rdy_mode == 2) ? 5 : 0;

    for (int cyc = 0; cyc < 3000 && !fin_seen; cyc++) begin
      @(negedge clk_i);
      test_start_i = 1'b0;
      cmd_done_i   = 1'b0;
      err_i        = 1'b0;
      // Configuration inputs must not be looked at after the start cycle.
      test_mode_i  = 2'($urandom);
      addr_mode_i  = 3'($urandom);
      base_addr_i  = $urandom;
      words_i      = 10'($urandom);
      trans_cnt_i  = 16'($urandom);

      if (start_chk) begin
        start_chk = 0;
        chk({name, ".start_busy"},   busy_o,       !degen);
        chk({name, ".start_valid"},  cmd_valid_o,  !degen);
        chk({name, ".start_finish"}, finish_o,     degen);
        chk({name, ".start_tdone"},  trans_done_o, 0);
        chk({name, ".start_err"},    err_o,        0);
      end
      if (follow) begin
        follow = 0;
        if (n_acc < exp_n) begin
          chk({name, ".next_valid"}, cmd_valid_o, 1);
          chk({name, ".next_busy"},  busy_o,      1);
        end else begin
          chk({name, ".end_finish"}, finish_o, 1);
          chk({name, ".end_busy"},   busy_o,   0);
        end
      end
      if (prev_acc) begin
        prev_acc = 0;
        chk({name, ".valid_drop"}, cmd_valid_o, 0);
      end
      if (held_valid) begin
        held_valid = 0;
        chk({name, ".hold_valid"},  cmd_valid_o, 1);
        chk({name, ".hold_fields"}, {cmd_type_o, cmd_addr_o, cmd_words_o}, held);
      end

      if (rst_k >= 0 && waiting && n_acc == rst_k + 1) begin
        cmd_ready_i = 1'b0;
        #2 rst_i = 1'b1;
        #1;
        chk({name, ".rst_outs"},
            {cmd_valid_o, busy_o, finish_o, err_o, cmd_type_o, cmd_addr_o, cmd_words_o, trans_done_o}, 0);
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
          @(negedge clk_i);
          chk({name, ".post_rst_quiet"}, {finish_o, busy_o, cmd_valid_o}, 0);
        end
        return;
      end

      if (finish_o) begin
        fin_seen = 1;
        chk({name, ".fin_tdone"}, trans_done_o, exp_td);
        chk({name, ".fin_err"},   err_o,        exp_err);
        chk({name, ".fin_ncmd"},  n_acc,        exp_n);
        chk({name, ".fin_valid"}, cmd_valid_o,  0);
      end else if (cmd_valid_o) begin
        if (stall > 0) begin
          stall--;
          cmd_ready_i = 1'b0;
        end else begin
          cmd_ready_i = (rdy_mode == 0) ? 1'b1 : ($urandom % 3 != 0);
        end
        if (cmd_ready_i) begin
          if (n_acc < exp_n) begin
            chk({name, ".cmd_type"},  cmd_type_o,  et[n_acc]);
            chk({name, ".cmd_addr"},  cmd_addr_o,  ea[n_acc]);
            chk({name, ".cmd_words"}, cmd_words_o, w);
          end else begin
            chk({name, ".extra_cmd"}, n_acc + 1, exp_n);
          end
          n_acc++;
          prev_acc  = 1;
          waiting   = 1;
          wait_ctr  = 1 + int'($urandom % 3);
          err_early = 1'($urandom);
          if ($urandom % 4 == 0) cmd_done_i = 1'b1;  // must be ignored
        end else begin
          held_valid = 1;
          held = {cmd_type_o, cmd_addr_o, cmd_words_o};
        end
      end else begin
        cmd_ready_i = 1'($urandom);
        if (busy_o && $urandom % 6 == 0) test_start_i = 1'b1;  // must be ignored
        if (waiting) begin
          if (n_acc - 1 == err_k && !err_sent && (wait_ctr == 1 || err_early)) begin
            err_i    = 1'b1;
            err_sent = 1;
          end
          wait_ctr--;
          if (wait_ctr == 0) begin
            cmd_done_i = 1'b1;
            waiting    = 0;
            follow     = 1;
          end
        end
      end
    end

    if (!fin_seen) begin
      chk({name, ".timeout"}, 0, 1);
    end else begin
      cmd_ready_i = 1'b0;
      @(negedge clk_i);
      chk({name, ".finish_pulse"}, finish_o, 0);
      chk({name, ".idle_busy"},    busy_o,   0);
      chk({name, ".err_sticky"},   err_o,    exp_err);
    end
  endtask

  initial begin
    logic [1:0]  r_mode;
    logic [2:0]  r_am;
    logic [15:0] r_cnt;
    int          r_err;

    rst_i = 1'b1; test_start_i = 1'b0; test_mode_i = '0; addr_mode_i = '0;
    base_addr_i = '0; words_i = '0; trans_cnt_i = '0;
    cmd_ready_i = 1'b0; cmd_done_i = 1'b0; err_i = 1'b0;
    repeat (3) @(negedge clk_i);
    chk("reset_outs",
        {cmd_valid_o, busy_o, finish_o, err_o, cmd_type_o, cmd_addr_o, cmd_words_o, trans_done_o}, 0);
    rst_i = 1'b0;
    @(negedge clk_i);
    err_i = 1'b1;
    @(negedge clk_i);
    err_i = 1'b0;
    chk("idle_err_ignored", err_o, 0);
    chk("idle_not_busy", busy_o, 0);

    run("wc_fix",    2'b11, 3'd0, 32'h0000_0100, 10'd4,  16'd3,  -1, 0, -1);
    run("wo_inc",    2'b10, 3'd4, 32'hFFFF_FFFE, 10'd2,  16'd3,  -1, 1, -1);
    run("ro_run1",   2'b01, 3'd3, 32'h1234_5678, 10'd1,  16'd34, -1, 1, -1);
    run("ro_run0",   2'b01, 3'd2, 32'h1234_5678, 10'd1,  16'd34, -1, 1, -1);
    run("rnd_zero",  2'b10, 3'd1, 32'h0000_0000, 10'd5,  16'd2,  -1, 1, -1);
    run("rnd_msb",   2'b01, 3'd1, 32'h8000_0000, 10'd7,  16'd4,  -1, 1, -1);
    run("wc_err_rd", 2'b11, 3'd4, 32'h0000_0040, 10'd8,  16'd10,  3, 1, -1);
    run("wc_err_wr", 2'b11, 3'd0, 32'h0000_0200, 10'd3,  16'd5,   2, 1, -1);
    run("bp",        2'b11, 3'd4, 32'h0000_1000, 10'd16, 16'd2,  -1, 2, -1);
    run("cnt0",      2'b10, 3'd0, 32'h0000_0100, 10'd4,  16'd0,  -1, 1, -1);
    run("mode0",     2'b00, 3'd0, 32'h0000_0100, 10'd4,  16'd3,  -1, 1, -1);
    run("am_bad",    2'b11, 3'd6, 32'h0000_0100, 10'd4,  16'd3,  -1, 1, -1);
    run("rst_rd",    2'b11, 3'd0, 32'h0000_0100, 10'd4,  16'd3,  -1, 0,  1);
    run("after_rst", 2'b11, 3'd1, 32'h0000_0000, 10'd9,  16'd3,  -1, 1, -1);

    for (int t = 0; t < 25; t++) begin
      r_mode = ($urandom % 10 == 0) ? 2'b00 : 2'(1 + $urandom % 3);
      r_am   = ($urandom % 8 == 0) ? 3'(5 + $urandom % 3) : 3'($urandom % 5);
      r_cnt  = 16'($urandom % 7);
      r_err  = ($urandom % 3 == 0) ? int'($urandom % (2 * 7 + 1)) : -1;
      run("rand", r_mode, r_am, $urandom, 10'($urandom), r_cnt, r_err, 1, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
